min_max_decimator: RTL
======================

Name: min_max_decimator

Overview:
- Parametrised successor of the single-channel 8-bit min/max stage in the acquisition path.
- Takes CHANNELS parallel ADC/LA sample streams and decimates them by a programmable interval.
- Per interval, emits one of: the last sample, the maximum, the minimum, or a max/min pair (peak-detect).
- Output feeds the SRAM write path as single-cycle strobes; there is no backpressure.

Parameters:
WIDTH, 8, bits per channel sample
CHANNELS, 2, number of independent channels sharing one interval counter
CNT_W, 16, width of DECIM and the interval counter

Ports:
CLK  in  1  system clock, all logic on rising edge
CLR  in  1  reset, asynchronous, active-high
EN  in  1  acquisition enable; low = idle and flush partial interval
IN_VALID  in  1  DATA_IN carries a sample this cycle
DATA_IN  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH], unsigned
MODE  in  2  0=sample(last), 1=peak pair, 2=max only, 3=min only
DECIM  in  CNT_W  interval length minus one, in accepted samples
OUT_VALID  out  1  one-cycle strobe, OUT_DATA valid
OUT_DATA  out  CHANNELS*WIDTH  result word, same packing as DATA_IN
OUT_IS_MIN  out  1  1 = OUT_DATA is a minimum word (modes 1 and 3)
BUSY  out  1  interval in progress or pair word pending

Behaviour:
- Reset (CLR high, asynchronous): OUT_VALID=0, OUT_DATA=0, OUT_IS_MIN=0, BUSY=0.
- Reset also clears the input register, counter, accumulators and pending flag.
- Reset mid-interval or mid-pair: partial results are discarded and no strobe is issued.
- Stage 1 input register: captures DATA_IN and IN_VALID into s1 each edge, qualified by EN.
- Stage 2 accumulator, per channel: max_acc, min_acc, last. Updates only when s1_valid.
  - First sample of an interval (cnt==0): load max_acc, min_acc and last from the sample.
  - Latch MODE and DECIM into mode_l and len_l at this point.
  - Otherwise: max_acc takes the sample if sample >= max_acc; min_acc takes the sample if sample <= min_acc; last takes the sample.
  - Comparisons are unsigned, WIDTH bits, with no arithmetic growth.
- Interval length L = len_l+1 samples. In mode 1, L = max(len_l+1, 2), so DECIM=0 behaves as 1.
- Counter: cnt increments on each s1_valid. On the final sample (cnt==L-1), cnt returns to 0.
- Output on the final-sample edge (word combined with the final sample):
  - mode 0: last. mode 2: max. mode 3: min, with OUT_IS_MIN=1.
  - mode 1: max with OUT_IS_MIN=0. The final min goes to pend_min and the pending flag is set.
- Pair second word: on the next edge, OUT_DATA=pend_min, OUT_IS_MIN=1, OUT_VALID=1, pending cleared.
  - L>=2 guarantees no collision with the next interval's result.
- Latency: sample presented with IN_VALID before edge k is final → OUT_VALID high after edge k+1. Pair min follows after edge k+2.
- OUT_VALID is high for exactly one cycle per word. OUT_DATA and OUT_IS_MIN hold their last value otherwise.
- IN_VALID gaps: counter and accumulators hold. The interval spans accepted samples only.
- MODE/DECIM changes mid-interval take effect at the next interval start.
- EN low: s1_valid forced 0, cnt=0, partial interval dropped, no strobe for it. A pending pair min is still emitted.
- EN high again: a fresh interval starts at the next accepted sample.
- DECIM at all-ones: cnt reaches 2^CNT_W-1 and wraps to 0 as a normal interval end.
- Channels are fully independent in compare; OUT_VALID, OUT_IS_MIN and the counter are shared.
- BUSY = (cnt!=0) | pending | s1_valid.

Test Plan:
- Mode 2, DECIM=3, ch0 inputs 10,200,50,7 back-to-back → single strobe OUT_DATA[7:0]=200, 2 edges after the 4th sample, OUT_IS_MIN=0.
- Mode 1, DECIM=3, ch0 10,200,50,7 and ch1 0,0,255,128 → first strobe ch0=200/ch1=255 (IS_MIN=0), next cycle ch0=7/ch1=0 (IS_MIN=1). Same pair for the following interval with no lost samples.
- Mode 1, DECIM=0, continuous 1,2,3,4 → pairs (2,1),(4,3); no strobe collision.
- Mode 0, DECIM=2, IN_VALID toggling 1,0,1,0,1 with data 5,x,6,x,9 → one strobe, OUT_DATA=9. Equal-value inputs 5,5,5 in mode 3 → 5 with IS_MIN=1.
- EN dropped after 2 of 4 samples, then restored → no strobe for the partial interval; next full interval of 4 produces the correct result.
- CLR pulsed during a pending pair min → OUT_VALID stays 0, BUSY=0, all outputs 0 immediately (asynchronous), clean restart afterward.

Source files
------------

// File: rtl/min_max_decimator.sv
// Multi-channel min/max/last decimator feeding the SRAM write path.
// Two stages: registered input sample, then per-channel accumulate with an interval counter.
module min_max_decimator #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      EN,
  input  logic                      IN_VALID,
  input  logic [CHANNELS*WIDTH-1:0] DATA_IN,
  input  logic [1:0]                MODE,
  input  logic [CNT_W-1:0]          DECIM,
  output logic                      OUT_VALID,
  output logic [CHANNELS*WIDTH-1:0] OUT_DATA,
  output logic                      OUT_IS_MIN,
  output logic                      BUSY
);

  localparam int DW = CHANNELS * WIDTH;
  localparam logic [1:0] M_LAST = 2'd0;
  localparam logic [1:0] M_PAIR = 2'd1;
  localparam logic [1:0] M_MAX  = 2'd2;
  localparam logic [1:0] M_MIN  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [WIDTH-1:0] pick_max(input logic [WIDTH-1:0] smp,
                                                input logic [WIDTH-1:0] acc);
    return (smp >= acc) ? smp : acc;
  endfunction

  function automatic logic [WIDTH-1:0] pick_min(input logic [WIDTH-1:0] smp,
                                                input logic [WIDTH-1:0] acc);
    return (smp <= acc) ? smp : acc;
  endfunction

  logic [DW-1:0]    data_p1;
  logic             vld_p1;

  logic [CNT_W-1:0] cnt_p2;
  logic [DW-1:0]    max_p2;
  logic [DW-1:0]    min_p2;
  logic [1:0]       mode_l;
  logic [CNT_W-1:0] len_l;
  logic             pend_p2;
  logic [DW-1:0]    pend_min_p2;

  logic             first_p1;
  logic [1:0]       mode_eff;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] last_idx;
  logic             final_p1;
  logic [DW-1:0]    max_nxt;
  logic [DW-1:0]    min_nxt;

  // ---- stage 1: input register ----
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= EN & IN_VALID;
      if (EN) data_p1 <= DATA_IN;
    end
  end

  // MODE/DECIM are sampled live on the first sample, latched copies apply afterwards.
  always_comb begin
    first_p1 = (cnt_p2 == '0);
    mode_eff = first_p1 ? MODE  : mode_l;
    len_eff  = first_p1 ? DECIM : len_l;
    last_idx = ((mode_eff == M_PAIR) && (len_eff == '0)) ? CNT_ONE : len_eff;
    final_p1 = vld_p1 & EN & (cnt_p2 == last_idx);
    max_nxt  = max_p2;
    min_nxt  = min_p2;
    for (int c = 0; c < CHANNELS; c++) begin
      max_nxt[c*WIDTH +: WIDTH] = first_p1 ? data_p1[c*WIDTH +: WIDTH]
                                  : pick_max(data_p1[c*WIDTH +: WIDTH], max_p2[c*WIDTH +: WIDTH]);
      min_nxt[c*WIDTH +: WIDTH] = first_p1 ? data_p1[c*WIDTH +: WIDTH]
                                  : pick_min(data_p1[c*WIDTH +: WIDTH], min_p2[c*WIDTH +: WIDTH]);
    end
  end

  // ---- stage 2: accumulate, count, emit ----
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt_p2      <= '0;
      max_p2      <= '0;
      min_p2      <= '0;
      mode_l      <= M_LAST;
      len_l       <= '0;
      pend_p2     <= 1'b0;
      pend_min_p2 <= '0;
      OUT_VALID   <= 1'b0;
      OUT_DATA    <= '0;
      OUT_IS_MIN  <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      if (!EN) begin
        cnt_p2 <= '0;
      end else if (vld_p1) begin
        cnt_p2 <= final_p1 ? '0 : cnt_p2 + CNT_ONE;
        max_p2 <= max_nxt;
        min_p2 <= min_nxt;
        if (first_p1) begin
          mode_l <= MODE;
          len_l  <= DECIM;
        end
      end
      // A pending pair min wins over a same-cycle result, which only a
      // mid-stream switch to a one-sample interval can produce.
      if (pend_p2) begin
        OUT_VALID  <= 1'b1;
        OUT_DATA   <= pend_min_p2;
        OUT_IS_MIN <= 1'b1;
        pend_p2    <= 1'b0;
      end else if (final_p1) begin
        OUT_VALID  <= 1'b1;
        OUT_IS_MIN <= (mode_eff == M_MIN);
        OUT_DATA   <= (mode_eff == M_LAST) ? data_p1 :
                      (mode_eff == M_MIN)  ? min_nxt : max_nxt;
        if (mode_eff == M_PAIR) begin
          pend_p2     <= 1'b1;
          pend_min_p2 <= min_nxt;
        end
      end
    end
  end

  assign BUSY = (cnt_p2 != '0) | pend_p2 | vld_p1;

endmodule
